// File: rtl/filter_pkg.sv
// Shared definitions for the debounce filter family (driver and receive side).
package filter_pkg;

  // Default dwell depth, common to the driver and the receive filter.
  localparam int DEFAULT_HOLD_TICKS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int calc_cw(input int hold_ticks);
    return $clog2(hold_ticks + 1);
  endfunction

endpackage

// File: rtl/filter_driver_hold_counter.sv
// Dwell tick counter: counts enabled ticks, wraps to zero on terminal count.
module hold_counter
  import filter_pkg::*;
#(
  parameter int HOLD_TICKS = DEFAULT_HOLD_TICKS,
  localparam int CW = calc_cw(HOLD_TICKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          ce,
  output logic [CW-1:0] q,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(HOLD_TICKS - 1);

  assign tc = ce && (q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= '0;
    end else if (tc) begin
      q <= '0;
    end else if (ce) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/filter_driver.sv
// Level driver that holds each new level for HOLD_TICKS ticks before the next change.
// Build option FILTER_DRIVER_SKID_EN adds a one-entry skid register for requests made during HOLD.
module filter_driver
  import filter_pkg::*;
#(
  parameter int   HOLD_TICKS = DEFAULT_HOLD_TICKS,
  parameter logic INIT_LEVEL = 1'b0,
  localparam int  CW         = calc_cw(HOLD_TICKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clock_enable,
  input  logic          req_level,
  input  logic          req_valid,
  output logic          req_ready,
  output logic          out_signal,
  output logic          out_signal_enable,
  output logic          busy,
  output logic [CW-1:0] q_count
);

  state_t state, state_nxt;
  logic   out_nxt;
  logic   pulse_nxt;
  logic   accept;
  logic   tc;

  hold_counter #(
    .HOLD_TICKS(HOLD_TICKS)
  ) u_hold_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(state != HOLD),
    .ce   (clock_enable && (state == HOLD)),
    .q    (q_count),
    .tc   (tc)
  );

  assign busy   = (state == HOLD);
  assign accept = req_valid && req_ready;

`ifdef FILTER_DRIVER_SKID_EN
  logic skid_valid, skid_valid_nxt;
  logic skid_level, skid_level_nxt;
  logic pend_valid;
  logic pend_level;

  // A parked entry blocks new requests in either state.
  assign req_ready  = !skid_valid;
  assign pend_valid = skid_valid || accept;
  assign pend_level = skid_valid ? skid_level : req_level;

  always_comb begin
    state_nxt      = state;
    out_nxt        = out_signal;
    pulse_nxt      = 1'b0;
    skid_valid_nxt = skid_valid;
    skid_level_nxt = skid_level;
    case (state)
      IDLE: begin
        if (skid_valid) begin
          out_nxt        = skid_level;
          pulse_nxt      = 1'b1;
          state_nxt      = HOLD;
          skid_valid_nxt = 1'b0;
        end else if (accept && (req_level != out_signal)) begin
          out_nxt   = req_level;
          pulse_nxt = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (tc) begin
          state_nxt      = IDLE;
          skid_valid_nxt = 1'b0;
          if (pend_valid && (pend_level != out_signal)) begin
            // With a one-tick hold the exit can land right after the change pulse;
            // park the level one cycle so pulses never run back to back.
            if (out_signal_enable) begin
              skid_valid_nxt = 1'b1;
              skid_level_nxt = pend_level;
            end else begin
              out_nxt   = pend_level;
              pulse_nxt = 1'b1;
              state_nxt = HOLD;
            end
          end
        end else if (accept) begin
          skid_valid_nxt = 1'b1;
          skid_level_nxt = req_level;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_level <= 1'b0;
    end else begin
      skid_valid <= skid_valid_nxt;
      skid_level <= skid_level_nxt;
    end
  end
`else
  assign req_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    out_nxt   = out_signal;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (req_level != out_signal)) begin
          out_nxt   = req_level;
          pulse_nxt = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (tc) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      out_signal        <= INIT_LEVEL;
      out_signal_enable <= 1'b0;
    end else begin
      state             <= state_nxt;
      out_signal        <= out_nxt;
      out_signal_enable <= pulse_nxt;
    end
  end

endmodule

// File: doc/filter_driver.md
Name: filter_driver

Overview:
- Transmit-side counterpart of the input debounce filter: drives one output line that any downstream debounce filter with the same tick rate and hold depth accepts cleanly.
- Accepts level-change requests over a valid/ready handshake and applies each accepted change on the line.
- Holds every new level for at least HOLD_TICKS clock_enable ticks before accepting the next request, so the line never toggles faster than the receiving filter can settle.
- Sits between control logic and output pins or inter-block wires; uses the same clock_enable tick strobe as the receive filters.

Parameters:
- HOLD_TICKS, 4: minimum dwell in clock_enable ticks after each committed level change; legal range 1..255.
- INIT_LEVEL, 1'b0: out_signal value after reset.
- CW, $clog2(HOLD_TICKS+1): width of q_count; derived, never overridden.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- clock_enable  input  1  tick strobe; the dwell counter advances only on cycles where it is 1.
- req_level  input  1  requested line level.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- out_signal  output  1  driven line; registered.
- out_signal_enable  output  1  one-cycle pulse in the cycle out_signal takes a new value.
- busy  output  1  1 while in HOLD.
- q_count  output  CW  dwell tick count; 0 outside HOLD.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - out_signal = INIT_LEVEL
  - state = IDLE
  - q_count = 0
  - out_signal_enable = 0
  - skid entry empty (feature build only)
- Reset takes priority over everything, including in the middle of a HOLD. The hold in progress is abandoned and the line returns to INIT_LEVEL.
- req_ready is combinational: 1 in IDLE, 0 in HOLD (base build). A handshake completes when req_valid and req_ready are both 1 at a clk edge.
- IDLE, accepted request with req_level != out_signal:
  - on the next edge, out_signal = req_level and out_signal_enable = 1 for exactly one cycle;
  - q_count = 0, state moves to HOLD;
  - latency from accept to line change is one clk.
- IDLE, accepted request with req_level == out_signal:
  - the request is consumed; no line change, no pulse, no HOLD.
- HOLD:
  - each cycle with clock_enable=1 increments q_count;
  - on a cycle with clock_enable=1 and q_count == HOLD_TICKS-1, the next edge sets state = IDLE and q_count = 0;
  - total dwell is exactly HOLD_TICKS ticks, counted from the first tick after the change edge;
  - clock_enable=0 freezes q_count;
  - req_level and req_valid are ignored.
- HOLD_TICKS=1: a single tick ends the HOLD.
- busy = (state == HOLD).
- q_count never exceeds HOLD_TICKS-1; there is no wrap.
- out_signal_enable is never asserted in two consecutive cycles.

Optional Feature:
- FILTER_DRIVER_SKID_EN defined:
  - adds a one-entry skid register;
  - in HOLD, req_ready = skid empty;
  - a request accepted during HOLD is stored;
  - on the HOLD exit edge, a stored differing level is applied directly: the line changes, a pulse is issued, a new HOLD starts with no IDLE cycle;
  - a stored equal level is dropped;
  - rst clears the skid.
- Undefined: base behaviour, req_ready = 0 throughout HOLD.

Decomposition:
- Package filter_pkg holds:
  - the state typedef (IDLE, HOLD);
  - a function computing CW from HOLD_TICKS;
  - the default HOLD_TICKS, shared with the receive filter.
- One sub-module, hold_counter: a tick counter with clear, CE, a terminal-count output and a q output.
  - The top holds only the FSM, the line register and the skid.

Test Plan:
- Reset then idle with HOLD_TICKS=4 and INIT_LEVEL=0: out_signal=0, req_ready=1, q_count=0, busy=0, no pulse for 20 cycles.
- Request level 1 with clock_enable high every cycle:
  - out_signal=1 one clk after the accept, pulse width 1 cycle;
  - busy for 4 cycles;
  - req_ready=1 again on cycle 5.
- clock_enable high every 3rd cycle, request 1 then 0 back-to-back under a held valid:
  - second accept occurs only after 4 ticks (about 12 cycles);
  - line shows 0→1→0 with 2 pulses total.
- Request the same level as the current line: consumed in one cycle, no pulse, busy stays 0.
- rst asserted at q_count=2 in HOLD: next cycle out_signal=INIT_LEVEL, q_count=0, busy=0, req_ready=1.
- FILTER_DRIVER_SKID_EN, request 1 then 0 accepted during HOLD:
  - 0 applied on the HOLD exit edge with a pulse and no IDLE gap;
  - the 1→0 interval is exactly 4 ticks.
